// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: shared FSM states, ALU command and operand-valid encodings.
package alu_arbiter_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_e;
    localparam logic [3:0] CMD_ADD = 4'd0, CMD_SUB = 4'd1, CMD_ADD_CIN = 4'd2, CMD_SUB_CIN = 4'd3,
                           CMD_INC_A = 4'd4, CMD_DEC_A = 4'd5, CMD_INC_B = 4'd6, CMD_DEC_B = 4'd7,
                           CMD_CMP = 4'd8, CMD_MUL_INC = 4'd9, CMD_MUL_SHL = 4'd10;
    localparam logic [3:0] CMD_AND = 4'd0, CMD_NAND = 4'd1, CMD_OR = 4'd2, CMD_NOR = 4'd3,
                           CMD_XOR = 4'd4, CMD_XNOR = 4'd5, CMD_NOT_A = 4'd6, CMD_NOT_B = 4'd7;
    localparam logic [1:0] INP_NONE = 2'b00, INP_A = 2'b01, INP_B = 2'b10, INP_AB = 2'b11;
endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester, response and ALU buses around the arbiter.
interface alu_arbiter_if #(parameter int WIDTH = 8);
    logic [1:0]              req_valid, req_ready, req_mode, req_cin;
    logic [1:0][3:0]         req_cmd;
    logic [1:0][WIDTH-1:0]   req_opa, req_opb;
    logic [1:0]              rsp_valid;
    logic [2*WIDTH-1:0]      rsp_res;
    logic                    rsp_err, rsp_oflow, rsp_cout, rsp_g, rsp_l, rsp_e;
    logic                    alu_ce, alu_mode, alu_cin;
    logic [1:0]              alu_inp_valid;
    logic [3:0]              alu_cmd;
    logic [WIDTH-1:0]        alu_opa, alu_opb;
    logic [2*WIDTH-1:0]      alu_res;
    logic                    alu_err, alu_oflow, alu_cout, alu_g, alu_l, alu_e;
    modport master (
        output req_valid, req_mode, req_cin, req_cmd, req_opa, req_opb,
               alu_res, alu_err, alu_oflow, alu_cout, alu_g, alu_l, alu_e,
        input  req_ready, rsp_valid, rsp_res, rsp_err, rsp_oflow, rsp_cout, rsp_g, rsp_l, rsp_e,
               alu_ce, alu_mode, alu_cin, alu_inp_valid, alu_cmd, alu_opa, alu_opb
    );
    modport slave (
        input  req_valid, req_mode, req_cin, req_cmd, req_opa, req_opb,
               alu_res, alu_err, alu_oflow, alu_cout, alu_g, alu_l, alu_e,
        output req_ready, rsp_valid, rsp_res, rsp_err, rsp_oflow, rsp_cout, rsp_g, rsp_l, rsp_e,
               alu_ce, alu_mode, alu_cin, alu_inp_valid, alu_cmd, alu_opa, alu_opb
    );
endinterface

// File: rtl/alu_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant; the pointer names the preferred requester.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] gnt_o
);
    logic ptr_q;
    always_comb gnt_o = req_i[ptr_q] ? 2'b01 << ptr_q : req_i[!ptr_q] ? 2'b01 << !ptr_q : 2'b00;
    always_ff @(posedge clk or posedge rst)
        if (rst) ptr_q <= 1'b0;
        else if (en_i && |gnt_o) ptr_q <= !gnt_o[1];
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one pipelined ALU between two requesters with round-robin
// grant, fixed-latency result capture and a WAIT timeout that forces an error response.
module alu_arbiter import alu_arbiter_pkg::*; #(
    parameter int WIDTH   = 8,
    parameter int LATENCY = 2,
    parameter int TIMEOUT = 15
) (
    input logic         clk,
    input logic         rst,
    alu_arbiter_if.slave bus_io
);
    localparam int TW = $clog2(TIMEOUT + 1);
    state_e             state_q, state_d;
    logic [2:0]         lat_q;
    logic [TW-1:0]      tmo_q;
    logic [1:0]         gnt;
    logic               take, sel, lat_done, tmo_hit;
    logic               owner_q, mode_q, cin_q;
    logic [3:0]         cmd_q;
    logic [WIDTH-1:0]   opa_q, opb_q;
    logic [2*WIDTH-1:0] res_q;
    logic [5:0]         flags_q;
    rr_arbiter2 u_rr (.clk(clk), .rst(rst), .req_i(bus_io.req_valid), .en_i(take), .gnt_o(gnt));
    assign take     = state_q == IDLE;
    assign sel      = gnt[1];
    assign lat_done = lat_q == 3'd1;
    assign tmo_hit  = tmo_q == TW'(1);
    always_ff @(posedge clk or posedge rst)
        if (rst) state_q <= IDLE;
        else state_q <= state_d;
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = |gnt ? ISSUE : IDLE;
            ISSUE:   state_d = WAIT;
            WAIT:    state_d = (lat_done || tmo_hit) ? RESPOND : WAIT;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        bus_io.req_ready     = (take && !rst) ? gnt : 2'b00;
        bus_io.alu_ce        = state_q == ISSUE || state_q == WAIT;
        bus_io.alu_inp_valid = state_q == ISSUE ? INP_AB : INP_NONE;
        bus_io.rsp_valid     = state_q == RESPOND ? 2'b01 << owner_q : 2'b00;
    end
    // Latency and timeout counters both load on ISSUE; a normal completion wins a tie.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            lat_q   <= '0;
            tmo_q   <= '0;
            owner_q <= 1'b0;
            mode_q  <= 1'b0;
            cin_q   <= 1'b0;
            cmd_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            flags_q <= '0;
        end else begin
            lat_q <= state_q == ISSUE ? 3'(LATENCY) : state_q == WAIT ? lat_q - 3'd1 : 3'd0;
            tmo_q <= state_q == ISSUE ? TW'(TIMEOUT) : state_q == WAIT ? tmo_q - TW'(1) : '0;
            if (take && |gnt) begin
                owner_q <= sel;
                mode_q  <= bus_io.req_mode[sel];
                cin_q   <= bus_io.req_cin[sel];
                cmd_q   <= bus_io.req_cmd[sel];
                opa_q   <= bus_io.req_opa[sel];
                opb_q   <= bus_io.req_opb[sel];
            end
            if (state_q == WAIT && (lat_done || tmo_hit)) begin
                res_q   <= lat_done ? bus_io.alu_res : '0;
                flags_q <= lat_done ? {bus_io.alu_err, bus_io.alu_oflow, bus_io.alu_cout,
                                       bus_io.alu_g, bus_io.alu_l, bus_io.alu_e} : 6'b100000;
            end
        end
    assign bus_io.alu_mode = mode_q;
    assign bus_io.alu_cin  = cin_q;
    assign bus_io.alu_cmd  = cmd_q;
    assign bus_io.alu_opa  = opa_q;
    assign bus_io.alu_opb  = opb_q;
    assign bus_io.rsp_res  = res_q;
    assign {bus_io.rsp_err, bus_io.rsp_oflow, bus_io.rsp_cout,
            bus_io.rsp_g, bus_io.rsp_l, bus_io.rsp_e} = flags_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: table-driven and randomized checks of alu_arbiter against a
// transaction-level model (grant order, issue/response timing, result transport).
module tb_alu_arbiter import alu_arbiter_pkg::*;;
    localparam int L = 2;
    localparam int LT = 5, TT = 3;
    typedef struct packed { logic [15:0] res; logic err, oflow, cout, g, l, e; } rsp_t;
    typedef struct { bit idx; logic mode; logic [3:0] cmd; logic [7:0] a, b; logic cin; logic [15:0] res; } vec_t;

    logic clk = 1'b0, rst = 1'b1;
    int vectors = 0, errs = 0;
    always #5 clk = ~clk;

    alu_arbiter_if #(.WIDTH(8)) m ();
    alu_arbiter_if #(.WIDTH(8)) t ();
    alu_arbiter #(.WIDTH(8)) u_dut (.clk(clk), .rst(rst), .bus_io(m));
    alu_arbiter #(.WIDTH(8), .LATENCY(LT), .TIMEOUT(TT)) u_tmo (.clk(clk), .rst(rst), .bus_io(t));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // External ALU behaviour; also the reference for what a request should return.
    function automatic rsp_t alu_fn(input logic md, input logic [3:0] c, input logic [7:0] a, b, input logic ci);
        rsp_t r = '0;
        logic [8:0] s;
        r.g = a > b; r.l = a < b; r.e = a == b;
        if (md) begin
            s = c == CMD_SUB ? {1'b0, a} - {1'b0, b} : {1'b0, a} + {1'b0, b} + (c == CMD_ADD_CIN ? {8'd0, ci} : 9'd0);
            r.res = {7'd0, s}; r.cout = s[8]; r.oflow = c == CMD_SUB && a < b;
        end else
            r.res = {8'd0, c == CMD_AND ? a & b : c == CMD_OR ? a | b : c == CMD_XOR ? a ^ b : ~a};
        return r;
    endfunction

    // ALU model: result valid only in the LATENCY-th cycle after the issue cycle.
    int cd = 0;
    rsp_t pend;
    always @(negedge clk) begin
        if (rst) cd = 0;
        else if (m.alu_inp_valid == 2'b11) begin
            cd = L + 1;
            pend = alu_fn(m.alu_mode, m.alu_cmd, m.alu_opa, m.alu_opb, m.alu_cin);
        end else if (cd != 0) cd--;
        if (cd == 1) {m.alu_res, m.alu_err, m.alu_oflow, m.alu_cout, m.alu_g, m.alu_l, m.alu_e} = pend;
        else {m.alu_res, m.alu_err, m.alu_oflow, m.alu_cout, m.alu_g, m.alu_l, m.alu_e} = 22'($urandom);
    end

    // Transaction-level reference: who may be granted when, and when results are due.
    int cyc = 0, next_free = 0, issue_at = -1, ce_from = 0, ce_to = -1;
    bit last = 1'b1;
    rsp_t expq[$];
    int dueq[$];
    bit ownq[$];
    logic [21:0] issue_ops;
    always @(negedge clk) begin
        logic [1:0] er, ev;
        bit w;
        cyc++;
        if (rst) begin
            expq.delete(); dueq.delete(); ownq.delete();
            last = 1'b1; next_free = 0; issue_at = -1; ce_to = -1;
        end else begin
            w = m.req_valid == 2'b11 ? !last : m.req_valid[1];
            er = (cyc >= next_free && |m.req_valid) ? 2'b01 << w : 2'b00;
            chk("req_ready", m.req_ready, er);
            if (|er) begin
                expq.push_back(alu_fn(m.req_mode[w], m.req_cmd[w], m.req_opa[w], m.req_opb[w], m.req_cin[w]));
                dueq.push_back(cyc + L + 2);
                ownq.push_back(w);
                issue_ops = {m.req_mode[w], m.req_cmd[w], m.req_opa[w], m.req_opb[w], m.req_cin[w]};
                last = w; next_free = cyc + L + 3; issue_at = cyc + 1; ce_from = cyc + 1; ce_to = cyc + L + 1;
            end
            chk("alu_inp_valid", m.alu_inp_valid, cyc == issue_at ? 2'b11 : 2'b00);
            chk("alu_ce", m.alu_ce, cyc >= ce_from && cyc <= ce_to);
            if (cyc == issue_at) chk("alu_ops", {m.alu_mode, m.alu_cmd, m.alu_opa, m.alu_opb, m.alu_cin}, issue_ops);
            ev = (dueq.size() != 0 && dueq[0] == cyc) ? 2'b01 << ownq[0] : 2'b00;
            chk("rsp_valid", m.rsp_valid, ev);
            if (|ev) begin
                chk("rsp_data", {m.rsp_res, m.rsp_err, m.rsp_oflow, m.rsp_cout, m.rsp_g, m.rsp_l, m.rsp_e}, expq[0]);
                void'(expq.pop_front()); void'(dueq.pop_front()); void'(ownq.pop_front());
            end
        end
    end

    task automatic run_op(input bit idx, input logic md, input logic [3:0] c, input logic [7:0] a, b,
                          input logic ci, output logic [15:0] res, output int lat);
        int n = 0;
        @(posedge clk); #1;
        m.req_mode[idx] = md; m.req_cmd[idx] = c; m.req_opa[idx] = a; m.req_opb[idx] = b;
        m.req_cin[idx] = ci; m.req_valid[idx] = 1'b1;
        do begin @(negedge clk); n++; end while (!m.req_ready[idx] && n < 40);
        @(posedge clk); #1;
        m.req_valid[idx] = 1'b0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!m.rsp_valid[idx] && lat < 40);
        res = m.rsp_res;
    endtask

    task automatic pulse_rst();
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
    endtask

    function automatic logic [63:0] outs_m();
        return {m.req_ready, m.rsp_valid, m.rsp_res, m.rsp_err, m.rsp_oflow, m.rsp_cout, m.rsp_g, m.rsp_l, m.rsp_e,
                m.alu_ce, m.alu_inp_valid, m.alu_mode, m.alu_cmd, m.alu_opa, m.alu_opb, m.alu_cin};
    endfunction

    function automatic logic [63:0] outs_t();
        return {t.req_ready, t.rsp_valid, t.rsp_res, t.rsp_err, t.rsp_oflow, t.rsp_cout, t.rsp_g, t.rsp_l, t.rsp_e,
                t.alu_ce, t.alu_inp_valid, t.alu_mode, t.alu_cmd, t.alu_opa, t.alu_opb, t.alu_cin};
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[8];
        logic [15:0] res;
        int lat, g, n, pulses;
        bit order[4];
        tbl[0] = '{1'b0, 1'b1, CMD_ADD,     8'h05, 8'h03, 1'b0, 16'h0008};
        tbl[1] = '{1'b1, 1'b1, CMD_SUB,     8'h0A, 8'h03, 1'b0, 16'h0007};
        tbl[2] = '{1'b0, 1'b1, CMD_ADD_CIN, 8'hFF, 8'h01, 1'b1, 16'h0101};
        tbl[3] = '{1'b1, 1'b0, CMD_AND,     8'hF0, 8'h3C, 1'b0, 16'h0030};
        tbl[4] = '{1'b0, 1'b0, CMD_OR,      8'hF0, 8'h0F, 1'b0, 16'h00FF};
        tbl[5] = '{1'b1, 1'b0, CMD_XOR,     8'hAA, 8'hFF, 1'b0, 16'h0055};
        tbl[6] = '{1'b1, 1'b1, CMD_ADD,     8'hFF, 8'hFF, 1'b0, 16'h01FE};
        tbl[7] = '{1'b0, 1'b0, CMD_NOT_A,   8'h0F, 8'h00, 1'b0, 16'h00F0};
        m.req_valid = '0; m.req_mode = '0; m.req_cin = '0; m.req_cmd = '0; m.req_opa = '0; m.req_opb = '0;
        t.req_valid = '0; t.req_mode = '0; t.req_cin = '0; t.req_cmd = '0; t.req_opa = '0; t.req_opb = '0;
        {t.alu_res, t.alu_err, t.alu_oflow, t.alu_cout, t.alu_g, t.alu_l, t.alu_e} = {16'hBEEF, 6'b111111};
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", outs_m(), 64'd0);
        chk("reset_outputs_tmo", outs_t(), 64'd0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("idle_outputs", outs_m(), 64'd0);

        foreach (tbl[i]) begin
            run_op(tbl[i].idx, tbl[i].mode, tbl[i].cmd, tbl[i].a, tbl[i].b, tbl[i].cin, res, lat);
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(L + 2));
            chk($sformatf("vec%0d_res", i), res, tbl[i].res);
        end

        // Contention: both requesters hold VALID across four operations.
        pulse_rst();
        @(posedge clk); #1;
        m.req_opa = 16'($urandom); m.req_opb = 16'($urandom); m.req_cmd = 8'($urandom); m.req_mode = 2'b11;
        m.req_valid = 2'b11;
        g = 0; n = 0;
        while (g < 4 && n < 100) begin
            @(negedge clk); n++;
            if (|(m.req_ready & m.req_valid)) begin order[g] = m.req_ready[1]; g++; end
        end
        chk("contention_grants", 64'(g), 64'd4);
        for (int i = 0; i < 4; i++) chk($sformatf("contention_order%0d", i), 64'(order[i]), 64'(i % 2));
        @(posedge clk); #1; m.req_valid = 2'b00;
        repeat (L + 4) @(posedge clk);

        // Reset while the ALU operation is in WAIT: the response must never appear.
        @(posedge clk); #1;
        m.req_valid[0] = 1'b1; m.req_mode[0] = 1'b1; m.req_cmd[0] = CMD_ADD; m.req_opa[0] = 8'h11; m.req_opb[0] = 8'h22;
        n = 0;
        do begin @(negedge clk); n++; end while (!m.req_ready[0] && n < 40);
        @(posedge clk); #1; m.req_valid[0] = 1'b0;
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        pulses = 0;
        repeat (10) begin @(negedge clk); if (|m.rsp_valid) pulses++; end
        chk("midwait_reset_no_rsp", 64'(pulses), 64'd0);
        run_op(1'b0, 1'b1, CMD_ADD, 8'h20, 8'h30, 1'b0, res, lat);
        chk("after_reset_latency", 64'(lat), 64'(L + 2));
        chk("after_reset_res", res, 16'h0050);

        // Early drop is exercised by run_op; this one targets requester 1 explicitly.
        run_op(1'b1, 1'b0, CMD_XOR, 8'h0F, 8'hF0, 1'b0, res, lat);
        chk("early_drop_latency", 64'(lat), 64'(L + 2));
        chk("early_drop_res", res, 16'h00FF);

        // Randomized traffic, scored by the reference model.
        g = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            m.req_valid = 2'($urandom); m.req_mode = 2'($urandom); m.req_cin = 2'($urandom);
            m.req_cmd = 8'($urandom); m.req_opa = 16'($urandom); m.req_opb = 16'($urandom);
            @(negedge clk);
            if (|(m.req_ready & m.req_valid)) g++;
        end
        @(posedge clk); #1; m.req_valid = 2'b00;
        repeat (L + 6) @(posedge clk);
        @(negedge clk);
        chk("random_grants_seen", 64'(g > 20), 64'd1);
        chk("random_drained", 64'(dueq.size()), 64'd0);

        // Timeout: TIMEOUT=3 with LATENCY=5 forces an error response.
        @(posedge clk); #1;
        t.req_valid[0] = 1'b1; t.req_mode[0] = 1'b1; t.req_cmd[0] = CMD_ADD; t.req_opa[0] = 8'h05; t.req_opb[0] = 8'h03;
        n = 0;
        do begin @(negedge clk); n++; end while (!t.req_ready[0] && n < 40);
        @(posedge clk); #1; t.req_valid[0] = 1'b0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!t.rsp_valid[0] && lat < 40);
        chk("timeout_latency", 64'(lat), 64'(TT + 2));
        chk("timeout_err_res", {t.rsp_err, t.rsp_res}, {1'b1, 16'h0000});
        @(posedge clk); #1; t.req_valid[1] = 1'b1;
        @(negedge clk);
        chk("timeout_back_to_idle", t.req_ready, 2'b10);
        @(posedge clk); #1; t.req_valid[1] = 1'b0;
        repeat (3) @(negedge clk);
        chk("timeout_rsp_hold", {t.rsp_err, t.rsp_res, t.rsp_valid}, {1'b1, 16'h0000, 2'b00});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, ALU operand width in bits.
REQ-002 Parameter LATENCY, default 2, ALU cycles from issue to valid RES, range 1..7.
REQ-003 Parameter TIMEOUT, default 15, maximum WAIT cycles before an error is forced.
REQ-004 CLK  input  1  single clock; all logic rising-edge.
REQ-005 RST  input  1  asynchronous, active-high reset.
REQ-006 REQ_VALID  input  2  per-requester operation request.
REQ-007 REQ_READY  output  2  per-requester accept; a transfer occurs when VALID and READY are both high.
REQ-008 REQ_MODE  input  2x1; REQ_CMD  input  2x4; REQ_OPA/REQ_OPB  input  2xWIDTH; REQ_CIN  input  2x1; per-requester operation fields.
REQ-009 RSP_VALID  output  2  one-cycle result strobe to the owning requester.
REQ-010 RSP_RES  output  2*WIDTH; RSP_ERR, RSP_OFLOW, RSP_COUT, RSP_G, RSP_L, RSP_E  output  1 each; shared result bus.
REQ-011 ALU_CE  output  1; ALU_INP_VALID  output  2; ALU_MODE  output  1; ALU_CMD  output  4; ALU_OPA/ALU_OPB  output  WIDTH; ALU_CIN  output  1; ALU drive side.
REQ-012 ALU_RES  input  2*WIDTH; ALU_ERR, ALU_OFLOW, ALU_COUT, ALU_G, ALU_L, ALU_E  input  1 each; ALU result side.

Function
REQ-013 FSM states: IDLE, ISSUE, WAIT, RESPOND; encoded in 2 bits.
REQ-014 IDLE: when any REQ_VALID is high, the block SHALL grant one requester round-robin, starting from the requester after the last one granted (requester 0 after reset), and go to ISSUE.
REQ-015 Only the granted requester's REQ_READY SHALL be high, for exactly the IDLE cycle in which the grant is made; its fields are captured in that cycle.
REQ-016 If both REQ_VALID are high, the requester that was not served most recently SHALL win; requests are never starved.
REQ-017 ISSUE: one cycle with ALU_CE=1, ALU_INP_VALID=2'b11, and captured MODE/CMD/OPA/OPB/CIN driven; then go to WAIT with the latency counter loaded with LATENCY.
REQ-018 WAIT: ALU_CE=1 and ALU_INP_VALID=2'b00; the counter decrements each cycle; when it reaches 0, the block SHALL sample all ALU_* result inputs and go to RESPOND.
REQ-019 WAIT exceeding TIMEOUT cycles SHALL force RESPOND with RSP_ERR=1 and RSP_RES=0.
REQ-020 RESPOND: RSP_VALID[owner] high for exactly one cycle, with the registered result on the RSP_* buses; then go to IDLE.
REQ-021 Issue-to-RSP_VALID latency SHALL be LATENCY+2 cycles; request throughput is one operation per LATENCY+3 cycles.
REQ-022 RSP_* buses SHALL hold the last result between responses; RSP_VALID SHALL be 0 outside RESPOND.
REQ-023 REQ_VALID dropped by a requester after it is granted SHALL NOT cancel the operation.
REQ-024 Outside ISSUE and WAIT, ALU_CE=0, ALU_INP_VALID=0, and the ALU operand outputs are held.

Reset
REQ-025 On RST, the FSM SHALL go to IDLE, the round-robin pointer to requester 0, and the counters to 0; REQ_READY, RSP_VALID, ALU_CE, ALU_INP_VALID and all RSP_*/ALU_* data outputs SHALL be 0.
REQ-026 RST asserted mid-operation SHALL drop the operation with no RSP_VALID pulse; after release, the first grant follows REQ-014.

Structure
REQ-027 A shared package SHALL hold the state enum, the CMD encodings (arithmetic and logical) and the INP_VALID encodings.
REQ-028 One sub-module, rr_arbiter2, SHALL contain the 2-way round-robin grant and pointer logic.

Verification
REQ-029 Reset: RST=1 for 2 cycles -> every output is 0 and the FSM is in IDLE.
REQ-030 Single request: requester 0, MODE=1, CMD=ADD, OPA=8'h05, OPB=8'h03 -> one ALU_INP_VALID=11 pulse; RSP_VALID[0] at LATENCY+2 cycles with RSP_RES=8; RSP_VALID[1] stays 0.
REQ-031 Contention: both REQ_VALID held high for 4 operations -> grants alternate 0,1,0,1.
REQ-032 Timeout: the ALU model never returns and the counter is forced via TIMEOUT=3 with a stalled latency -> RSP_ERR=1 and RSP_RES=0, then back to IDLE.
REQ-033 Reset mid-WAIT -> no RSP_VALID pulse; a new request completes normally.
REQ-034 Early drop: requester 1 deasserts REQ_VALID one cycle after REQ_READY -> the result is still delivered on RSP_VALID[1].
